instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the pipeline's instruction decoder: packs instruction fields (opcode, func3, func7, rs1, rs2, rd, imm) into 32-bit RV32 instruction words.
- Streams each packed word with an auto-incrementing word address to the instruction-memory write port.
- Used as the program loader and test-program generator ahead of the core.
- The imm input uses the decoder's output format, so decoder output fed back into this block reproduces the original instruction.

Parameters:
- AW, 8, instruction-memory word-address width; capacity is 2**AW words.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; clears address/FIFO and enters LOAD (honoured only in IDLE/DONE)
- in_valid  in  1  field bundle valid
- in_ready  out  1  block accepts bundle
- in_last  in  1  final instruction of program
- opcode  in  7  instruction opcode
- func3  in  3  funct3
- func7  in  7  funct7 (R-type only)
- rs1, rs2, rd  in  5 each  register indices
- imm  in  21  immediate, decoder format (B/J already shifted right 1)
- out_valid  out  1  packed word valid
- out_ready  in  1  memory accepts word
- out_addr  out  AW  word address of out_instr
- out_instr  out  32  packed instruction
- err  out  1  one-cycle pulse: bundle rejected
- err_code  out  2  reason, held until next rejection: 01 bad opcode, 11 bad func3, 10 imm range
- busy  out  1  state is LOAD or DRAIN
- done  out  1  state is DONE

Behaviour:
- Reset: state IDLE, FIFO empty, address 0.
  - All outputs 0 (out_instr 0, out_addr 0, err_code 00).
- Supported opcodes and packing:
  - R 0110011: {func7, rs2, rs1, func3, rd, op}.
  - I 0010011, L 0000011, JALR 1100111: {imm[11:0], rs1, func3, rd, op}.
  - S 0100011: {imm[11:5], rs2, rs1, func3, imm[4:0], op}.
  - B 1100011: [31]=imm[11], [30:25]=imm[9:4], [24:20]=rs2, [19:15]=rs1, [14:12]=func3, [11:8]=imm[3:0], [7]=imm[10], op.
  - JAL 1101111: [31]=imm[19], [30:21]=imm[9:0], [20]=imm[10], [19:12]=imm[18:11], rd, op.
  - Fields unused by the format are ignored.
- Checks, in priority order:
  - Opcode not in the supported set -> code 01.
  - func3 illegal -> code 11. Legal values: S/L {000, 010}; B {000, 100, 101}; JALR 000.
  - imm out of range -> code 10. Rule: imm[20:12] must be 0 for I/L/S/B/JALR; imm[20] must be 0 for JAL.
- Rejected bundle:
  - Consumed normally (handshake completes) and not pushed; address unchanged.
  - err pulses for 1 cycle and err_code updates, in the cycle after acceptance.
- Handshakes:
  - Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
  - out_* held stable while out_valid && !out_ready.
- 2-entry output FIFO:
  - Accepted word is registered at the next edge; out_valid is asserted 1 cycle after acceptance when the FIFO is empty.
  - in_ready = (state==LOAD) && (count<2). Computed from registered count; a same-cycle pop does not raise it.
  - With out_ready held high, throughput is 1 word/cycle.
- Address:
  - Assigned at push from a push counter; increments by 1 per push.
  - Push at address 2**AW-1 forces LOAD->DRAIN. There is no wrap; later inputs are not accepted.
- FSM transitions:
  - IDLE -start-> LOAD.
  - LOAD -> DRAIN on an accepted in_last (pushed or rejected) or on a push at the max address.
  - DRAIN -> DONE when the FIFO is empty.
  - DONE -start-> LOAD; start clears the address to 0.
  - start in LOAD/DRAIN is ignored.
- Simultaneous push and pop in one cycle: count unchanged, order preserved.
- Reset mid-operation: FIFO contents discarded immediately (out_valid falls asynchronously); state IDLE.

Optional Feature:
- Macro: INSTR_ENCODER_STATS_EN.
- Defined:
  - Adds outputs enc_count [15:0] (pushed words) and rej_count [15:0] (rejected bundles).
  - Both counters saturate at 0xFFFF, are cleared on honoured start and on reset, and update in the cycle after acceptance.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- start; addi x1,x0,5 (op 0010011, rd 1, f3 0, rs1 0, imm 5) with out_ready=1 -> out_valid next cycle, out_instr 0x00500093, out_addr 0.
- Stream, each expected at increasing out_addr 0..4:
  - add x3,x1,x2 (f7 0) -> 0x002081B3.
  - sw x2,8(x1) (f3 010, imm 8) -> 0x0020A423.
  - beq x1,x2 with imm 4 -> 0x00208463.
  - jal x1 with imm 8, in_last=1 -> 0x010000EF.
  - Then done=1 after the FIFO drains.
- Rejections, none pushed and address unchanged:
  - op 0110111 -> err pulse, code 01.
  - L with f3 111 -> code 11.
  - addi with imm 0x01000 -> code 10.
- Backpressure: out_ready=0, 3 valid bundles -> in_ready low after 2 accepts, out_instr stable. Raise out_ready -> third accepted, order and addresses 0,1,2 preserved.
- AW=2, 6 valid bundles, no in_last -> 4 pushes at addrs 0..3, then in_ready=0, DRAIN->DONE. Then start -> next word at addr 0.
- rst_n low while 2 words are buffered -> out_valid=0 immediately, busy=0, done=0. A following start restarts from addr 0.

Source files
------------

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input and packed-word output handshakes of the instruction encoder.
interface instr_encoder_if #(
    parameter int AW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic          in_last;
    logic [6:0]    opcode;
    logic [2:0]    func3;
    logic [6:0]    func7;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
    logic [20:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [31:0]   out_instr;
    modport master (
        output in_valid, in_last, opcode, func3, func7, rs1, rs2, rd, imm, out_ready,
        input  in_ready, out_valid, out_addr, out_instr
    );
    modport slave (
        input  in_valid, in_last, opcode, func3, func7, rs1, rs2, rd, imm, out_ready,
        output in_ready, out_valid, out_addr, out_instr
    );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs RV32 fields into instruction words and streams them with word addresses.
// Optional INSTR_ENCODER_STATS_EN adds saturating enc_count/rej_count outputs.
module instr_encoder #(
    parameter int AW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    instr_encoder_if.slave bus,
    output logic           err,
    output logic [1:0]     err_code,
    output logic           busy,
    output logic           done
`ifdef INSTR_ENCODER_STATS_EN
    ,
    output logic [15:0]    enc_count,
    output logic [15:0]    rej_count
`endif
);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            rp_q, rp_d, wp_q, wp_d;
    logic [AW+31:0]  mem_q [2];
    logic [AW+31:0]  mem_d [2];
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic            is_r, is_i, is_l, is_jalr, is_s, is_b, is_jal, known, f3_bad, imm_bad;
    logic [1:0]      code;
    logic [31:0]     instr;
    logic            accept, push, pop, clr;

    assign is_r    = bus.opcode == 7'b0110011;
    assign is_i    = bus.opcode == 7'b0010011;
    assign is_l    = bus.opcode == 7'b0000011;
    assign is_jalr = bus.opcode == 7'b1100111;
    assign is_s    = bus.opcode == 7'b0100011;
    assign is_b    = bus.opcode == 7'b1100011;
    assign is_jal  = bus.opcode == 7'b1101111;
    assign known   = is_r || is_i || is_l || is_jalr || is_s || is_b || is_jal;
    assign f3_bad  = ((is_s || is_l) && !(bus.func3 == 3'b000 || bus.func3 == 3'b010)) ||
                     (is_b && !(bus.func3 == 3'b000 || bus.func3 == 3'b100 || bus.func3 == 3'b101)) ||
                     (is_jalr && bus.func3 != 3'b000);
    assign imm_bad = is_jal ? bus.imm[20] : (!is_r && bus.imm[20:12] != 9'd0);
    assign code    = !known ? 2'b01 : f3_bad ? 2'b11 : imm_bad ? 2'b10 : 2'b00;

    // imm arrives in decoder format, so B/J offsets are already halved
    assign instr = is_r   ? {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode}
                 : is_s   ? {bus.imm[11:5], bus.rs2, bus.rs1, bus.func3, bus.imm[4:0], bus.opcode}
                 : is_b   ? {bus.imm[11], bus.imm[9:4], bus.rs2, bus.rs1, bus.func3, bus.imm[3:0], bus.imm[10], bus.opcode}
                 : is_jal ? {bus.imm[19], bus.imm[9:0], bus.imm[10], bus.imm[18:11], bus.rd, bus.opcode}
                 :          {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, bus.opcode};

    assign bus.in_ready  = state_q == LOAD && cnt_q < 2'd2;
    assign bus.out_valid = cnt_q != 2'd0;
    assign {bus.out_addr, bus.out_instr} = mem_q[rp_q];
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && code == 2'b00;
    assign pop    = bus.out_valid && bus.out_ready;
    assign clr    = start && (state_q == IDLE || state_q == DONE);
    assign err      = err_q;
    assign err_code = code_q;
    assign busy     = state_q == LOAD || state_q == DRAIN;
    assign done     = state_q == DONE;

    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wp_q] = {addr_q, instr};
        wp_d    = wp_q ^ push;
        rp_d    = rp_q ^ pop;
        cnt_d   = cnt_q + 2'(push) - 2'(pop);
        addr_d  = clr ? '0 : push ? addr_q + AW'(1) : addr_q;
        err_d   = accept && code != 2'b00;
        code_d  = err_d ? code : code_q;
        state_d = clr ? LOAD
                : (state_q == LOAD && accept && (bus.in_last || (push && addr_q == '1))) ? DRAIN
                : (state_q == DRAIN && cnt_q == 2'd0) ? DONE
                : state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            rp_q    <= 1'b0;
            wp_q    <= 1'b0;
            mem_q   <= '{default: '0};
            err_q   <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            mem_q   <= mem_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

`ifdef INSTR_ENCODER_STATS_EN
    logic [15:0] enc_q, enc_d, rej_q, rej_d;
    always_comb begin
        enc_d = clr ? '0 : (push && enc_q != 16'hFFFF) ? enc_q + 16'd1 : enc_q;
        rej_d = clr ? '0 : (err_d && rej_q != 16'hFFFF) ? rej_q + 16'd1 : rej_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_q <= '0;
            rej_q <= '0;
        end else begin
            enc_q <= enc_d;
            rej_q <= rej_d;
        end
    end
    assign enc_count = enc_q;
    assign rej_count = rej_q;
`endif
endmodule
